dcache: RTL
===========

# dcache

Direct-mapped, write-through, no-write-allocate data cache that sits between the pipeline's memory stage and the slower data memory. It is the initiating end of the data-memory interface: it serves load hits combinationally, and on a load miss it refills a full line from memory with a req/ack handshake. Every store is written through to memory. The memory stage is stalled until each access completes.

## Interface
- LINES, default 8: number of cache lines; power of two.
- WORDS, default 4: 32-bit words per line; power of two.
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- memread, in, 1: load request from the memory stage.
- memwrite, in, 1: store request from the memory stage.
- addr, in, 32: byte address; bits [1:0] ignored (word aligned).
- wdata, in, 32: store data.
- rdata, out, 32: load data; valid when memread=1 and stall=0.
- stall, out, 1: holds the memory stage and all earlier stages.
- mem_req, out, 1: memory transaction request.
- mem_we, out, 1: 1 = write, 0 = read; meaningful only while mem_req=1.
- mem_addr, out, 32: word-aligned byte address of the transaction.
- mem_wdata, out, 32: write data.
- mem_rdata, in, 32: read data; valid in the cycle mem_ack=1.
- mem_ack, in, 1: transaction completes at the rising edge where mem_req=1 and mem_ack=1.

## Operation
- Address split:
  - [1:0] byte offset.
  - Next log2(WORDS) bits: word offset.
  - Next log2(LINES) bits: index.
  - Remainder: tag.
- hit = valid[index] and tag match.
- Per line storage: valid bit, tag, WORDS data words.
- States:
  - IDLE: no memory transaction.
    - memwrite=1 -> WRITE (memwrite wins if memread is also 1; that combination is illegal).
    - memread=1 and miss -> REFILL, with the word counter cleared to 0.
    - memread=1 and hit -> stays IDLE; rdata = line word; stall=0.
  - REFILL: mem_req=1, mem_we=0, mem_addr = {tag, index, counter, 2'b00}.
    - On each ack: mem_rdata is written into word[counter] and the counter increments.
    - On the ack with counter=WORDS-1: tag is written, valid is set, state -> IDLE.
  - WRITE: mem_req=1, mem_we=1, mem_addr = addr with [1:0]=0, mem_wdata = wdata.
    - On ack: if hit, the cached word is updated with wdata in the same edge (no allocate on miss); state -> IDLE.
- Outputs in IDLE: mem_req=0; mem_we, mem_addr and mem_wdata are don't-care.
- mem_req, mem_we, mem_addr and mem_wdata are held stable from request until ack.
- stall is combinational:
  - 1 in REFILL.
  - 1 in WRITE unless mem_ack=1.
  - 1 in IDLE when memwrite=1, or when memread=1 and miss.
  - 0 otherwise.
- addr, wdata, memread and memwrite are held stable by the pipeline while stall=1.

## Timing
- Load hit: 0 extra cycles.
- Load miss: 1 detect cycle + WORDS acked transfers + 1 hit cycle. With zero-wait memory (ack in the first request cycle) that is 6 cycles at WORDS=4.
- Store: 1 detect cycle + the acked write. stall drops in the ack cycle, so the pipeline advances on that same edge. That is 2 cycles with zero-wait memory.
- A new request may be issued in the cycle after an ack; mem_req may stay high across back-to-back refill words.
- Reset asserted (rst=0):
  - valid bits cleared, state IDLE, counter 0.
  - mem_req=0 and stall=0 immediately, asynchronously, including mid-refill (the partial line stays invalid).
  - rdata = 0.
- Data and tag arrays are not reset.
- mem_ack while mem_req=0 is ignored.

## Structure
- Shared package dcache_pkg holds:
  - The state enum: IDLE, REFILL, WRITE.
  - Field-width functions derived from LINES and WORDS.
  - Field-extract helpers for tag, index and word offset.
- Sub-module dcache_array holds the valid, tag and data storage:
  - Combinational read port.
  - Line-fill write port (single word, with tag/valid update on the last word).
  - Word-update write port.
  - Asynchronous active-low valid clear.
- The FSM, counter and handshake logic live in dcache.

## Test plan
- Cold load at addr 0x00000040; memory returns 0xA0..0xA3 with 2-cycle ack latency:
  - Four reads at 0x40, 0x44, 0x48, 0x4C.
  - rdata = 0xA0 when stall drops.
  - A following load at 0x4C hits with 0 stall, rdata = 0xA3.
- Store 0x12345678 to 0x44 after that line is filled:
  - A single write with mem_addr=0x44 is issued.
  - stall drops in the ack cycle.
  - A load at 0x44 then hits with rdata = 0x12345678.
- Store to uncached 0x200:
  - The write goes to memory.
  - A following load at 0x200 misses and refills (no allocate).
- Conflict: load 0x40 then load 0xC0 (same index, different tag):
  - The second access refills.
  - A reload of 0x40 misses again.
- Reset mid-refill after 2 acks:
  - mem_req=0 and stall=0 immediately.
  - After release, load 0x40 misses and refetches all 4 words.
- Zero-wait memory (ack tied high while requested):
  - Load miss completes in 6 cycles.
  - Store completes in 2 cycles.
  - memread and memwrite together perform the write only.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: FSM states, address field widths
// and field-extract helpers, all derived from the LINES/WORDS geometry.
package dcache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  function automatic int unsigned word_bits(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned index_bits(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned lines, input int unsigned words);
    return ADDR_W - BYTE_W - word_bits(words) - index_bits(lines);
  endfunction

  // Helpers return the field right-justified in a full address word.
  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] a,
                                                input int unsigned words);
    return (a >> BYTE_W) & ADDR_W'(words - 1);
  endfunction

  function automatic logic [ADDR_W-1:0] index_of(input logic [ADDR_W-1:0] a,
                                                 input int unsigned lines,
                                                 input int unsigned words);
    return (a >> (BYTE_W + word_bits(words))) & ADDR_W'(lines - 1);
  endfunction

  function automatic logic [ADDR_W-1:0] tag_of(input logic [ADDR_W-1:0] a,
                                               input int unsigned lines,
                                               input int unsigned words);
    return a >> (BYTE_W + word_bits(words) + index_bits(lines));
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Data-memory bus between the cache (master) and data memory (slave).
// mem_req/mem_we/mem_addr/mem_wdata: request, held until the ack edge.
// mem_rdata/mem_ack: response; a transfer completes on req & ack at clk rise.
interface dcache_if;
  import dcache_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage of the direct-mapped cache.
// rd_*: combinational read of one line's valid, tag and one data word.
// fill_*: refill write of one word; the last word also writes tag and valid.
// upd_*: store-hit update of one data word.
// Only the valid bits are reset (asynchronously, active low).
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int unsigned LINES = 8,
  parameter  int unsigned WORDS = 4,
  localparam int unsigned IW    = index_bits(LINES),
  localparam int unsigned WB    = word_bits(WORDS),
  localparam int unsigned TW    = tag_bits(LINES, WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     rd_index,
  input  logic [WB-1:0]     rd_word,
  output logic              rd_valid,
  output logic [TW-1:0]     rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              fill_en,
  input  logic              fill_last,
  input  logic [IW-1:0]     fill_index,
  input  logic [WB-1:0]     fill_word,
  input  logic [TW-1:0]     fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              upd_en,
  input  logic [IW-1:0]     upd_index,
  input  logic [WB-1:0]     upd_word,
  input  logic [DATA_W-1:0] upd_data
);

  logic [LINES-1:0]  valid_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES][WORDS];

  // A line only becomes valid once its last word has landed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en && fill_last) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[fill_index][fill_word] <= fill_data;
      if (fill_last) begin
        tag_q[fill_index] <= fill_tag;
      end
    end
    if (upd_en) begin
      data_q[upd_index][upd_word] <= upd_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index][rd_word];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Pipeline side: memread/memwrite/addr/wdata in, rdata/stall out.
// Memory side: dcache_if master (req/ack handshake, one word per transfer).
// Load hits return combinationally; misses refill a whole line; every store
// is written through and updates the cached word only on a hit.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 8,
  parameter int unsigned WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  dcache_if.master          mem
);

  localparam int unsigned IW = index_bits(LINES);
  localparam int unsigned WB = word_bits(WORDS);
  localparam int unsigned TW = tag_bits(LINES, WORDS);
  localparam int unsigned LW = ADDR_W - BYTE_W - WB;

  state_e            state;
  logic [WB-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [WB-1:0]     word;
  logic [TW-1:0]     tag;
  logic [LW-1:0]     line_addr;
  logic              arr_valid;
  logic [TW-1:0]     arr_tag;
  logic [DATA_W-1:0] arr_data;
  logic              hit;
  logic              xfer;
  logic              fill_en;
  logic              fill_last;
  logic              upd_en;

  assign idx       = IW'(index_of(addr, LINES, WORDS));
  assign word      = WB'(word_of(addr, WORDS));
  assign tag       = TW'(tag_of(addr, LINES, WORDS));
  assign line_addr = addr[ADDR_W-1:BYTE_W+WB];

  assign hit       = arr_valid && (arr_tag == tag);
  assign xfer      = mem.mem_req && mem.mem_ack;
  assign fill_en   = (state == REFILL) && xfer;
  assign fill_last = (cnt == WB'(WORDS - 1));
  assign upd_en    = (state == WRITE) && xfer && hit;

  dcache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index   (idx),
    .rd_word    (word),
    .rd_valid   (arr_valid),
    .rd_tag     (arr_tag),
    .rd_data    (arr_data),
    .fill_en    (fill_en),
    .fill_last  (fill_last),
    .fill_index (idx),
    .fill_word  (cnt),
    .fill_tag   (tag),
    .fill_data  (mem.mem_rdata),
    .upd_en     (upd_en),
    .upd_index  (idx),
    .upd_word   (word),
    .upd_data   (wdata)
  );

  // Control FSM with registered bus outputs; the request is set up on the
  // edge leaving IDLE and advanced to the next refill word on each ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (memwrite) begin
            state         <= WRITE;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= 1'b1;
            mem.mem_addr  <= {addr[ADDR_W-1:BYTE_W], 2'b00};
            mem.mem_wdata <= wdata;
          end else if (memread && !hit) begin
            state        <= REFILL;
            cnt          <= '0;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= {line_addr, {WB{1'b0}}, 2'b00};
          end
        end
        REFILL: begin
          if (xfer) begin
            if (fill_last) begin
              state       <= IDLE;
              mem.mem_req <= 1'b0;
            end else begin
              cnt          <= cnt + 1'b1;
              mem.mem_addr <= {line_addr, cnt + WB'(1), 2'b00};
            end
          end
        end
        WRITE: begin
          if (xfer) begin
            state       <= IDLE;
            mem.mem_req <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          mem.mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Stall is forced low while reset is held so the pipeline is released at once.
  always_comb begin
    stall = 1'b0;
    if (rst) begin
      case (state)
        IDLE:    stall = memwrite | (memread & ~hit);
        REFILL:  stall = 1'b1;
        WRITE:   stall = ~mem.mem_ack;
        default: stall = 1'b0;
      endcase
    end
  end

  // Valid bits clear asynchronously, so rdata is zero during reset.
  assign rdata = (memread && (state == IDLE) && hit) ? arr_data : '0;

endmodule
